// File: rtl/activation_pipe.sv
// activation_pipe: 3-stage, LANES-wide PWL sigmoid/tanh/ReLU/identity unit.
// Ports: clk, reset (async, active-low); mode/in_valid/in_ready/in_data/in_tag
// input stream; out_valid/out_ready/out_data/out_tag output stream;
// sat_count/sat_clear saturation-event counter.
module activation_pipe #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [CNT_WIDTH-1:0]   sat_count,
  input  logic                   sat_clear
);

  localparam logic [1:0] M_SIG  = 2'd0;
  localparam logic [1:0] M_TANH = 2'd1;
  localparam logic [1:0] M_RELU = 2'd2;
  localparam logic [1:0] M_ID   = 2'd3;

  typedef logic signed [WIDTH-1:0] smp_t;
  typedef logic signed [WIDTH+1:0] wide_t;

  localparam longint ONE_L = longint'(1) << FRAC_WIDTH;

  localparam smp_t MAX_V  = smp_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam smp_t MIN_V  = smp_t'({1'b1, {(WIDTH-1){1'b0}}});
  localparam smp_t ONE    = smp_t'(ONE_L);
  localparam smp_t HALF   = smp_t'(ONE_L >>> 1);
  localparam smp_t C_625  = smp_t'((5 * ONE_L) >>> 3);
  localparam smp_t C_844  = smp_t'((27 * ONE_L) >>> 5);
  localparam smp_t T_2375 = smp_t'((19 * ONE_L) >>> 3);
  localparam smp_t T_5    = smp_t'(5 * ONE_L);
  localparam smp_t T_3P   = smp_t'(3 * ONE_L);
  localparam smp_t T_3N   = smp_t'(-3 * ONE_L);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int SUM_W = CNT_WIDTH + $clog2(LANES + 1) + 1;

  // Global stall: every stage moves together, bubbles are kept.
  logic en;
  logic acc;

  logic                 v1_q, v1_d;
  logic [1:0]           m1_q, m1_d;
  logic [TAG_WIDTH-1:0] t1_q, t1_d;
  smp_t                 x1_q [LANES];
  smp_t                 x1_d [LANES];
  smp_t                 a1_q [LANES];
  smp_t                 a1_d [LANES];
  logic [LANES-1:0]     n1_q, n1_d;

  logic                 v2_q, v2_d;
  logic [1:0]           m2_q, m2_d;
  logic [TAG_WIDTH-1:0] t2_q, t2_d;
  smp_t                 x2_q [LANES];
  smp_t                 x2_d [LANES];
  smp_t                 s2_q [LANES];
  smp_t                 s2_d [LANES];
  logic [LANES-1:0]     sat2_q, sat2_d;

  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
  logic [LANES-1:0]       sat3_q, sat3_d;

  logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;
  logic [SUM_W-1:0]     sum;

  assign en        = out_ready | ~out_valid_q;
  assign in_ready  = reset & en;
  assign acc       = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign sat_count = sat_count_q;

  // S1: argument select (x or saturated 2x) and magnitude.
  always_comb begin
    smp_t x;
    smp_t arg;
    x    = '0;
    arg  = '0;
    v1_d = v1_q;
    m1_d = m1_q;
    t1_d = t1_q;
    n1_d = n1_q;
    for (int i = 0; i < LANES; i++) begin
      x1_d[i] = x1_q[i];
      a1_d[i] = a1_q[i];
    end
    if (en) begin
      v1_d = acc;
      m1_d = mode;
      t1_d = in_tag;
      for (int i = 0; i < LANES; i++) begin
        x = smp_t'(in_data[i*WIDTH +: WIDTH]);
        if (mode != M_TANH) begin
          arg = x;
        end else if (x[WIDTH-1] != x[WIDTH-2]) begin
          // 2x left the WIDTH range
          arg = x[WIDTH-1] ? MIN_V : MAX_V;
        end else begin
          arg = {x[WIDTH-2:0], 1'b0};
        end
        n1_d[i] = arg[WIDTH-1];
        if (arg == MIN_V) begin
          a1_d[i] = MAX_V;
        end else if (arg[WIDTH-1]) begin
          a1_d[i] = -arg;
        end else begin
          a1_d[i] = arg;
        end
        x1_d[i] = x;
      end
    end
  end

  // S2: PWL sigmoid magnitude plus odd symmetry.
  always_comb begin
    smp_t a;
    smp_t p;
    logic big;
    a      = '0;
    p      = '0;
    big    = 1'b0;
    v2_d   = v2_q;
    m2_d   = m2_q;
    t2_d   = t2_q;
    sat2_d = sat2_q;
    for (int i = 0; i < LANES; i++) begin
      x2_d[i] = x2_q[i];
      s2_d[i] = s2_q[i];
    end
    if (en) begin
      v2_d = v1_q;
      m2_d = m1_q;
      t2_d = t1_q;
      for (int i = 0; i < LANES; i++) begin
        a   = a1_q[i];
        big = 1'b0;
        unique case (1'b1)
          (a >= T_5): begin
            p   = ONE;
            big = 1'b1;
          end
          (a >= T_2375 && a < T_5): p = (a >>> 5) + C_844;
          (a >= ONE && a < T_2375): p = (a >>> 3) + C_625;
          default: p = (a >>> 2) + HALF;
        endcase
        s2_d[i] = n1_q[i] ? ONE - p : p;
        // curve saturation only matters for sigmoid/tanh beats
        sat2_d[i] = big & ~m1_q[1];
        x2_d[i] = x1_q[i];
      end
    end
  end

  // S3: per-mode result and final clamp.
  always_comb begin
    wide_t y;
    logic  sat;
    y           = '0;
    sat         = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    sat3_d      = sat3_q;
    if (en) begin
      out_valid_d = v2_q;
      out_tag_d   = t2_q;
      for (int i = 0; i < LANES; i++) begin
        sat = sat2_q[i];
        unique case (m2_q)
          M_SIG:  y = wide_t'(s2_q[i]);
          M_TANH: begin
            y = (wide_t'(s2_q[i]) <<< 1) - wide_t'(ONE);
            if (x2_q[i] >= T_3P) begin
              y   = wide_t'(ONE);
              sat = 1'b1;
            end else if (x2_q[i] <= T_3N) begin
              y   = -wide_t'(ONE);
              sat = 1'b1;
            end
          end
          M_RELU: y = x2_q[i][WIDTH-1] ? '0 : wide_t'(x2_q[i]);
          M_ID:   y = wide_t'(x2_q[i]);
        endcase
        if (y > wide_t'(MAX_V)) begin
          y   = wide_t'(MAX_V);
          sat = 1'b1;
        end else if (y < wide_t'(MIN_V)) begin
          y   = wide_t'(MIN_V);
          sat = 1'b1;
        end
        out_data_d[i*WIDTH +: WIDTH] = y[WIDTH-1:0];
        sat3_d[i] = sat;
      end
    end
  end

  // Saturation counter: clear wins, otherwise add on output acceptance.
  always_comb begin
    sum = SUM_W'(sat_count_q);
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(sat3_q[i]);
    end
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_valid_q & out_ready) begin
      if (sum > SUM_W'(CNT_MAX)) begin
        sat_count_d = CNT_MAX;
      end else begin
        sat_count_d = sum[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      m1_q        <= '0;
      t1_q        <= '0;
      n1_q        <= '0;
      v2_q        <= 1'b0;
      m2_q        <= '0;
      t2_q        <= '0;
      sat2_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      sat3_q      <= '0;
      sat_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        x1_q[i] <= '0;
        a1_q[i] <= '0;
        x2_q[i] <= '0;
        s2_q[i] <= '0;
      end
    end else begin
      v1_q        <= v1_d;
      m1_q        <= m1_d;
      t1_q        <= t1_d;
      n1_q        <= n1_d;
      v2_q        <= v2_d;
      m2_q        <= m2_d;
      t2_q        <= t2_d;
      sat2_q      <= sat2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      sat3_q      <= sat3_d;
      sat_count_q <= sat_count_d;
      for (int i = 0; i < LANES; i++) begin
        x1_q[i] <= x1_d[i];
        a1_q[i] <= a1_d[i];
        x2_q[i] <= x2_d[i];
        s2_q[i] <= s2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: scoreboard bench for activation_pipe.
// Drives beats on posedge+1, observes on negedge.
module tb_activation_pipe;

  localparam int IW  = 8;
  localparam int FW  = 8;
  localparam int W   = IW + FW + 1;
  localparam int L   = 4;
  localparam int TW  = 4;
  localparam int CW  = 4;
  localparam int ONE = 1 << FW;
  localparam int CMX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        mode = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [L*W-1:0]    in_data = '0;
  logic [TW-1:0]     in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [L*W-1:0]    out_data;
  logic [TW-1:0]     out_tag;
  logic [CW-1:0]     sat_count;
  logic              sat_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [L*W-1:0] data;
    logic [TW-1:0]  tag;
    int             nsat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   sat_model = 0;
  int   n_out = 0;
  int   nsat_acc;
  logic prev_stall = 1'b0;
  logic [L*W-1:0] prev_data;
  logic [TW-1:0]  prev_tag;
  bit   bp_done;

  always #5 clk = ~clk;

  activation_pipe #(
    .INT_WIDTH (IW),
    .FRAC_WIDTH(FW),
    .LANES     (L),
    .TAG_WIDTH (TW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .sat_count(sat_count),
    .sat_clear(sat_clear)
  );

  function automatic int lane_ref(input int x, input int m, output int sat);
    int maxv = (1 << (W-1)) - 1;
    int minv = -(1 << (W-1));
    int arg, a, p, s, y;
    sat = 0;
    if (m == 2) begin
      y = (x < 0) ? 0 : x;
    end else if (m == 3) begin
      y = x;
    end else begin
      arg = (m == 1) ? 2 * x : x;
      if (arg > maxv) arg = maxv;
      if (arg < minv) arg = minv;
      a = (arg < 0) ? -arg : arg;
      if (a > maxv) a = maxv;
      if (a >= 5 * ONE) begin
        p = ONE;
        sat = 1;
      end else if (8 * a >= 19 * ONE) begin
        p = a / 32 + (27 * ONE) / 32;
      end else if (a >= ONE) begin
        p = a / 8 + (5 * ONE) / 8;
      end else begin
        p = a / 4 + ONE / 2;
      end
      s = (arg < 0) ? ONE - p : p;
      if (m == 0) begin
        y = s;
      end else begin
        y = 2 * s - ONE;
        if (x >= 3 * ONE) begin
          y = ONE;
          sat = 1;
        end else if (x <= -3 * ONE) begin
          y = -ONE;
          sat = 1;
        end
      end
    end
    if (y > maxv) begin
      y = maxv;
      sat = 1;
    end else if (y < minv) begin
      y = minv;
      sat = 1;
    end
    return y;
  endfunction

  function automatic exp_t beat_ref(input logic [L*W-1:0] d,
                                    input logic [1:0] m,
                                    input logic [TW-1:0] t);
    exp_t r;
    int s, y;
    r.data = '0;
    r.tag  = t;
    r.nsat = 0;
    for (int i = 0; i < L; i++) begin
      y = lane_ref(int'($signed(d[i*W +: W])), int'(m), s);
      r.data[i*W +: W] = W'(y);
      r.nsat += s;
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] pack4(input int a0, input int a1,
                                           input int a2, input int a3);
    logic [L*W-1:0] r;
    r[0*W +: W] = W'(a0);
    r[1*W +: W] = W'(a1);
    r[2*W +: W] = W'(a2);
    r[3*W +: W] = W'(a3);
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      sat_model  = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (sat_count !== CW'(sat_model)) begin
        errors++;
        $display("FAIL sat_count: got %0d want %0d", sat_count, sat_model);
      end
      checks++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        errors++;
        $display("FAIL in_ready: got %b want %b", in_ready, out_ready | ~out_valid);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h/%h want v=1 %h/%h",
                   out_valid, out_data, out_tag, prev_data, prev_tag);
        end
      end
      nsat_acc = 0;
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got tag %h with empty scoreboard", out_tag);
        end else begin
          e = sbq.pop_front();
          nsat_acc = e.nsat;
          if (out_data !== e.data || out_tag !== e.tag) begin
            errors++;
            $display("FAIL out_beat: got %h/%h want %h/%h", out_data, out_tag, e.data, e.tag);
          end
        end
      end
      if (sat_clear) sat_model = 0;
      else if (out_valid && out_ready)
        sat_model = (sat_model + nsat_acc > CMX) ? CMX : sat_model + nsat_acc;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      if (in_valid && in_ready) sbq.push_back(beat_ref(in_data, mode, in_tag));
    end
  end

  task automatic send(input logic [1:0] m, input logic [L*W-1:0] d,
                      input logic [TW-1:0] t);
    int n = 0;
    mode = m;
    in_data = d;
    in_tag = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for tag %h", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got v=%b r=%b want 0 0", out_valid, in_ready);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0", out_data, out_tag);
    end
    checks++;
    if (sat_count !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", sat_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sigmoid();
    logic [L*W-1:0] want;
    want = pack4(128, 192, 64, 256);
    clear_cnt();
    send(2'd0, pack4(0, 256, -256, 1280), 4'h1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sig_lat1: got %b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sig_lat2: got %b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== want || out_tag !== 4'h1) begin
      errors++;
      $display("FAIL sig_out: got v=%b %h/%h want 1 %h/1", out_valid, out_data, out_tag, want);
    end
    @(negedge clk);
    checks++;
    if (sat_count !== 4'd1) begin
      errors++;
      $display("FAIL sig_sat: got %0d want 1", sat_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tanh();
    logic [L*W-1:0] want;
    want = pack4(192, 256, -256, 0);
    clear_cnt();
    send(2'd1, pack4(256, 768, -768, 0), 4'h2);
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== want || out_tag !== 4'h2) begin
      errors++;
      $display("FAIL tanh_out: got v=%b %h/%h want 1 %h/2", out_valid, out_data, out_tag, want);
    end
    @(negedge clk);
    checks++;
    if (sat_count !== 4'd2) begin
      errors++;
      $display("FAIL tanh_sat: got %0d want 2", sat_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [L*W-1:0] d, wa;
    d  = pack4(-5, 7, 0, -32768);
    wa = pack4(0, 7, 0, 0);
    send(2'd2, d, 4'h3);
    send(2'd3, d, 4'h9);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== wa || out_tag !== 4'h3) begin
      errors++;
      $display("FAIL b2b_relu: got v=%b %h/%h want 1 %h/3", out_valid, out_data, out_tag, wa);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_tag !== 4'h9) begin
      errors++;
      $display("FAIL b2b_ident: got v=%b %h/%h want 1 %h/9", out_valid, out_data, out_tag, d);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int base;
    base = n_out;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(2'(i % 4),
               pack4(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024,
                     int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024),
               4'(i + 4));
        end
        bp_done = 1'b1;
      end
      begin
        int k = 0;
        while ((!bp_done || sbq.size() != 0 || out_valid) && k < 400) begin
          out_ready = (k % 3 == 0);
          @(posedge clk);
          #1;
          k++;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (n_out - base !== 8) begin
      errors++;
      $display("FAIL bp_count: got %0d beats want 8", n_out - base);
    end
  endtask

  task automatic test_counter_limits();
    logic [L*W-1:0] d;
    int n = 0;
    d = pack4(1280, 1280, 1280, 1280);
    clear_cnt();
    for (int i = 0; i < 5; i++) send(2'd0, d, 4'(i));
    wait_idle();
    checks++;
    if (sat_count !== 4'd15) begin
      errors++;
      $display("FAIL cnt_cap: got %0d want 15", sat_count);
    end
    out_ready = 1'b0;
    send(2'd0, d, 4'h7);
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got out_valid=%b want 1", out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    checks++;
    if (sat_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio: got cnt=%0d v=%b want 0 0", sat_count, out_valid);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [L*W-1:0] d;
    int n = 0;
    d = pack4(1280, 1280, 1280, 1280);
    clear_cnt();
    send(2'd0, d, 4'h1);
    wait_idle();
    checks++;
    if (sat_count !== 4'd4) begin
      errors++;
      $display("FAIL rst_pre: got %0d want 4", sat_count);
    end
    out_ready = 1'b0;
    send(2'd1, pack4(100, -100, 800, 0), 4'h2);
    send(2'd2, d, 4'h3);
    send(2'd0, d, 4'h4);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill: got out_valid=%b want 1", out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sat_count !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got v=%b cnt=%0d r=%b want 0 0 0", out_valid, sat_count, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(2'd0, pack4(0, 0, 0, 0), 4'hA);
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    checks++;
    if (n !== 3 || out_tag !== 4'hA || out_data !== pack4(128, 128, 128, 128)) begin
      errors++;
      $display("FAIL rst_first: got lat=%0d tag=%h %h want 3 a", n, out_tag, out_data);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_sigmoid();
    test_tanh();
    test_back_to_back();
    test_backpressure();
    test_counter_limits();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Multi-lane, pipelined, mode-selectable fixed-point activation unit; successor to the single-lane combinational sigmoid/tanh pair.
- Sits between the GRU gate MAC outputs and the state-update datapath.
- Computes sigmoid, tanh, ReLU or identity on LANES signed Q(INT_WIDTH).(FRAC_WIDTH) values per beat.
- Uses shift-add piecewise-linear (PWL) arithmetic and a valid/ready stream handshake, with a tag sideband and a saturation-event counter.

Parameters:
- INT_WIDTH, 8, integer bits, excluding sign; must be ≥ 4.
- FRAC_WIDTH, 8, fractional bits; must be ≥ 3.
- WIDTH, INT_WIDTH+FRAC_WIDTH+1, signed sample width.
- LANES, 4, parallel samples per beat.
- TAG_WIDTH, 4, sideband carried unchanged from input to output.
- CNT_WIDTH, 16, saturation counter width.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  per-beat select, sampled with in_valid&in_ready: 0 sigmoid, 1 tanh, 2 ReLU, 3 identity.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input accepted when in_valid&in_ready.
- in_data  in  LANES*WIDTH  packed samples; lane i = [i*WIDTH +: WIDTH].
- in_tag  in  TAG_WIDTH  beat tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*WIDTH  results, same packing.
- out_tag  out  TAG_WIDTH  tag of the beat in out_data.
- sat_count  out  CNT_WIDTH  running count of saturated lane results.
- sat_clear  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (reset=0, async):
  - all stage valid bits, out_valid, out_data, out_tag and sat_count go to 0.
  - in_ready = 0 while reset is asserted.
  - A beat in flight when reset asserts is discarded, with no partial output.
- Pipeline:
  - 3 registered stages S1→S2→S3; out_data/out_tag/out_valid are the S3 registers.
  - Latency is exactly 3 cycles from acceptance to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Flow control:
  - Global enable: en = out_ready | ~out_valid.
  - in_ready = en (when out of reset).
  - When en=1, all stages shift and a bubble enters S1 if no beat is accepted.
  - When en=0, all stage registers hold; out_data and out_tag are stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed.
- S1 (per lane):
  - Register x, mode and tag.
  - Compute a = |arg|, where arg = x for sigmoid, or 2x for tanh. 2x is computed at WIDTH+1 bits and saturated to the WIDTH range.
  - |most-negative| saturates to the most-positive value.
  - Record sign(arg).
- S2, PWL sigmoid magnitude p(a), using constants scaled by 2^FRAC_WIDTH and arithmetic right shifts with truncation:
  - a ≥ 5.0: p = 1.0 (flag sat).
  - 2.375 ≤ a < 5.0: p = (a>>5) + 0.84375.
  - 1.0 ≤ a < 2.375: p = (a>>3) + 0.625.
  - a < 1.0: p = (a>>2) + 0.5.
  - Apply symmetry: s = p if arg ≥ 0, else 1.0 − p.
- S3, mode result:
  - sigmoid: y = s.
  - tanh: y = 2s − 1.0.
  - tanh override: if x ≥ 3.0 then y = +1.0; if x ≤ −3.0 then y = −1.0. Either case flags sat.
  - ReLU: y = max(x, 0).
  - identity: y = x.
  - All results are clamped to [min, max] of WIDTH; a clamp flags sat.
- sat_count:
  - On each cycle where an output beat is accepted (out_valid & out_ready), add the number of saturated lanes (0..LANES).
  - Saturates at 2^CNT_WIDTH−1 and does not wrap.
  - sat_clear has priority: if sat_clear and an acceptance occur in the same cycle, the result is 0.
- Mode and tag travel with their beat; mixed modes in consecutive beats are legal.

Test Plan:
1. Sigmoid, FRAC=8, lanes {0, 256, −256, 1280}, mode=0 → out_data {128, 192, 64, 256} exactly 3 cycles after acceptance; sat_count += 1.
2. Tanh, lanes {256, 768, −768, 0}, mode=1 → {192, 256, −256, 0}; sat_count += 2.
3. ReLU/identity back-to-back: beat A mode=2 {−5, 7, 0, −32768}, beat B mode=3 with the same data:
   - A → {0, 7, 0, 0}.
   - B → {−5, 7, 0, −32768}.
   - Tags 3 and 9 emerge with their own beats on consecutive cycles.
4. Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,… → no beat lost or duplicated; out_data is stable while stalled; in_ready == out_ready | ~out_valid every cycle.
5. Reset mid-stream: assert reset with 3 beats in flight → out_valid = 0 and sat_count = 0 immediately (asynchronously); after release, the first output comes only from a newly accepted beat.
6. Counter limits:
   - CNT_WIDTH=4: drive saturating beats → sat_count stops at 15.
   - sat_clear coincident with an accepted saturating beat → sat_count = 0.
